// File: rtl/fifo_ctrl_pkg.sv
// Constants shared by the FIFO controller, the register file and neighbouring datapath blocks.
package fifo_ctrl_pkg;

   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DATA_W = 32;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer handshake of the FIFO controller; the FIFO sits on the slave modport.
interface fifo_ctrl_if
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = RF_DATA_W
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: clears on reset or clr, otherwise advances by one on inc.
module fifo_ptr #(
   parameter int unsigned PTR_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   logic [PTR_W-1:0] ptr_d, ptr_q;

   // Natural overflow of the PTR_W-bit add gives the wrap to zero.
   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller around an external asynchronous-read register file (show-ahead head).
// Optional almost_full/almost_empty flags are built when FIFO_CTRL_ALMOST_FLAGS_EN is defined.
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 5,
   parameter int unsigned WIDTH      = RF_DATA_W
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
   ,
   parameter int unsigned AF_TH      = 2**DEPTH_LOG2 - 2,
   parameter int unsigned AE_TH      = 2
`endif
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                flush,
   fifo_ctrl_if.slave          io,
   output logic                rf_we,
   output rf_addr_t            rf_wa,
   output logic [WIDTH-1:0]    rf_wd,
   output rf_addr_t            rf_ra,
   input  logic [WIDTH-1:0]    rf_rd,
   output logic [DEPTH_LOG2:0] count,
   output logic                full,
   output logic                empty
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
   ,
   output logic                almost_full,
   output logic                almost_empty
`endif
);

   localparam int unsigned      CNT_W   = DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0] ENTRIES = CNT_W'(2**DEPTH_LOG2);

   logic [CNT_W-1:0]      count_d, count_q;
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic                  push, pop;

   assign full          = (count_q == ENTRIES);
   assign empty         = (count_q == '0);
   assign io.in_ready   = !full;
   assign io.out_valid  = !empty;

   // Flush and reset both block the write so nothing lands in the register file that cycle.
   assign push = io.in_valid & io.in_ready & !flush & rstn;
   assign pop  = io.out_valid & io.out_ready;

   assign rf_we       = push;
   assign rf_wa       = RF_ADDR_W'(wr_ptr);
   assign rf_wd       = io.in_data;
   assign rf_ra       = RF_ADDR_W'(rd_ptr);
   assign io.out_data = rf_rd;

   fifo_ptr #(
      .PTR_W (DEPTH_LOG2)
   ) u_wr_ptr (
      .clk  (clk),
      .rstn (rstn),
      .clr  (flush),
      .inc  (push),
      .ptr  (wr_ptr)
   );

   fifo_ptr #(
      .PTR_W (DEPTH_LOG2)
   ) u_rd_ptr (
      .clk  (clk),
      .rstn (rstn),
      .clr  (flush),
      .inc  (pop),
      .ptr  (rd_ptr)
   );

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
   logic almost_full_q, almost_empty_q;

   // Derived from count_d so the flags move on the same edge as count.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         almost_full_q  <= (32'(count_d) >= AF_TH);
         almost_empty_q <= (32'(count_d) <= AE_TH);
      end
   end

   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with a behavioural register file.
// Exercises the almost flags on a second instance when FIFO_CTRL_ALMOST_FLAGS_EN is defined.
module tb_fifo_ctrl;
   import fifo_ctrl_pkg::*;

   localparam int unsigned DL = 2;

   logic          clk = 1'b0;
   logic          rstn;
   logic          flush;
   logic          rf_we;
   rf_addr_t      rf_wa, rf_ra;
   logic [31:0]   rf_wd, rf_rd;
   logic [DL:0]   count;
   logic          full, empty;
   logic [31:0]   rf_mem [32];
   int unsigned   n_checks = 0;
   int unsigned   n_fail   = 0;

   fifo_ctrl_if #(.WIDTH(32)) bus ();

   always #5 clk = ~clk;

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
   logic af4, ae4;
`endif

   fifo_ctrl #(
      .DEPTH_LOG2 (DL),
      .WIDTH      (32)
   ) u_dut (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .io    (bus),
      .rf_we (rf_we),
      .rf_wa (rf_wa),
      .rf_wd (rf_wd),
      .rf_ra (rf_ra),
      .rf_rd (rf_rd),
      .count (count),
      .full  (full),
      .empty (empty)
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
      ,
      .almost_full  (af4),
      .almost_empty (ae4)
`endif
   );

   always @(posedge clk) begin
      if (rf_we) rf_mem[rf_wa] <= rf_wd;
   end
   assign rf_rd = rf_mem[rf_ra];

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
   fifo_ctrl_if #(.WIDTH(32)) bus8 ();
   logic        rf_we8, full8, empty8, af8, ae8;
   rf_addr_t    rf_wa8, rf_ra8;
   logic [31:0] rf_wd8;
   logic [3:0]  count8;

   fifo_ctrl #(
      .DEPTH_LOG2 (3),
      .WIDTH      (32)
   ) u_dut8 (
      .clk          (clk),
      .rstn         (rstn),
      .flush        (flush),
      .io           (bus8),
      .rf_we        (rf_we8),
      .rf_wa        (rf_wa8),
      .rf_wd        (rf_wd8),
      .rf_ra        (rf_ra8),
      .rf_rd        (32'h0),
      .count        (count8),
      .full         (full8),
      .empty        (empty8),
      .almost_full  (af8),
      .almost_empty (ae8)
   );
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      flush         = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   initial begin
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b0;
      bus8.in_data   = '0;
`endif
      // Reset with a handshake offered on both sides: nothing may be written.
      rstn          = 1'b0;
      flush         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hdead;
      bus.out_ready = 1'b1;
      step();
      check("rst_we", 32'(rf_we), 0);
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_in_ready", 32'(bus.in_ready), 1);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      step();
      idle();
      rstn = 1'b1;

      // Three pushes then three pops in order.
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h11;
      #1;
      check("s1_we", 32'(rf_we), 1);
      check("s1_wa0", 32'(rf_wa), 0);
      check("s1_ov_same_cycle", 32'(bus.out_valid), 0);
      step();
      check("s1_ov_next", 32'(bus.out_valid), 1);
      check("s1_head", bus.out_data, 32'h11);
      bus.in_data = 32'h22;
      step();
      bus.in_data = 32'h33;
      step();
      bus.in_valid = 1'b0;
      #1;
      check("s1_count", 32'(count), 3);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("s1_pop_data", bus.out_data, 32'(32'h11 * (i + 1)));
         step();
      end
      bus.out_ready = 1'b0;
      #1;
      check("s1_empty", 32'(empty), 1);
      check("s1_count0", 32'(count), 0);

      // Fill a 4-entry FIFO, stall the fifth push, pop one, see the write wrap.
      do_reset();
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = 32'ha0 + 32'(i);
         #1;
         check("s2_wa", 32'(rf_wa), 32'(i));
         step();
      end
      check("s2_full", 32'(full), 1);
      check("s2_count4", 32'(count), 4);
      check("s2_in_ready", 32'(bus.in_ready), 0);
      bus.in_data = 32'ha4;
      #1;
      check("s2_stall_we", 32'(rf_we), 0);
      step();
      check("s2_stall_count", 32'(count), 4);
      bus.out_ready = 1'b1;
      #1;
      check("s2_pop_only_we", 32'(rf_we), 0);
      step();
      bus.out_ready = 1'b0;
      #1;
      check("s2_count3", 32'(count), 3);
      check("s2_we5", 32'(rf_we), 1);
      check("s2_wa_wrap", 32'(rf_wa), 0);
      step();
      bus.in_valid = 1'b0;
      #1;
      check("s2_refull", 32'(full), 1);
      check("s2_head", bus.out_data, 32'ha1);
      check("s2_ra", 32'(rf_ra), 1);

      // Drain to two entries, then push and pop together.
      bus.out_ready = 1'b1;
      step();
      step();
      bus.out_ready = 1'b0;
      #1;
      check("s3_count2", 32'(count), 2);
      check("s3_head", bus.out_data, 32'ha3);
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h55;
      bus.out_ready = 1'b1;
      #1;
      check("s3_we", 32'(rf_we), 1);
      check("s3_wa", 32'(rf_wa), 1);
      step();
      idle();
      #1;
      check("s3_count_hold", 32'(count), 2);
      check("s3_head_adv", bus.out_data, 32'ha4);
      check("s3_ra_wrap", 32'(rf_ra), 0);

      // Third entry, then flush with a push offered.
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h66;
      step();
      check("s4_count3", 32'(count), 3);
      flush       = 1'b1;
      bus.in_data = 32'h77;
      #1;
      check("s4_flush_we", 32'(rf_we), 0);
      step();
      idle();
      #1;
      check("s4_count0", 32'(count), 0);
      check("s4_empty", 32'(empty), 1);
      check("s4_out_valid", 32'(bus.out_valid), 0);
      check("s4_in_ready", 32'(bus.in_ready), 1);
      check("s4_rf_kept", rf_mem[2], 32'h66);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h88;
      #1;
      check("s4_wa0", 32'(rf_wa), 0);
      step();
      bus.in_valid = 1'b0;
      #1;
      check("s4_count1", 32'(count), 1);
      check("s4_head", bus.out_data, 32'h88);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      #1;
      check("s4_drained", 32'(empty), 1);

      // Reset mid-stream with four entries held (pointers sit at 1).
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = 32'hc0 + 32'(i);
         step();
      end
      check("s5_count4", 32'(count), 4);
      rstn          = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("s5_rst_we", 32'(rf_we), 0);
      step();
      rstn = 1'b1;
      idle();
      #1;
      check("s5_count0", 32'(count), 0);
      check("s5_out_valid", 32'(bus.out_valid), 0);
      check("s5_in_ready", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h99;
      #1;
      check("s5_wa0", 32'(rf_wa), 0);
      step();
      bus.in_valid = 1'b0;
      #1;
      check("s5_head", bus.out_data, 32'h99);

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
      // 8-entry instance, default thresholds 6 and 2.
      do_reset();
      #1;
      check("af_reset", 32'(af8), 0);
      check("ae_reset", 32'(ae8), 1);
      bus8.in_valid = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         bus8.in_data = 32'(k);
         step();
         check("af_level", 32'(af8), (k >= 6) ? 32'd1 : 32'd0);
         check("ae_level", 32'(ae8), (k <= 2) ? 32'd1 : 32'd0);
      end
      bus8.in_valid = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 5, meaning log2 of entry count; 2**DEPTH_LOG2 entries, max 5 for a 32-entry register file.
REQ-002 SHALL have parameter WIDTH, default 32, meaning data width.
REQ-003 SHALL have port clk  input  1  meaning sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  meaning synchronous active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port flush  input  1  meaning synchronous clear of contents.
REQ-006 SHALL have port in_valid  input  1  meaning the producer offers in_data.
REQ-007 SHALL have port in_ready  output  1  meaning the block accepts a push this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  meaning push data.
REQ-009 SHALL have port out_valid  output  1  meaning out_data holds the head entry.
REQ-010 SHALL have port out_ready  input  1  meaning the consumer takes the head entry.
REQ-011 SHALL have port out_data  output  WIDTH  meaning head entry data.
REQ-012 SHALL have port rf_we  output  1  meaning register-file write enable.
REQ-013 SHALL have port rf_wa  output  5  meaning register-file write address.
REQ-014 SHALL have port rf_wd  output  WIDTH  meaning register-file write data.
REQ-015 SHALL have port rf_ra  output  5  meaning register-file read address.
REQ-016 SHALL have port rf_rd  input  WIDTH  meaning register-file asynchronous read data for rf_ra.
REQ-017 SHALL have port count  output  DEPTH_LOG2+1  meaning current occupancy.
REQ-018 SHALL have ports full and empty  output  1 each  meaning occupancy == 2**DEPTH_LOG2 and occupancy == 0.

Function
REQ-019 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-020 SHALL drive in_ready = !full and out_valid = !empty combinationally from registered state.
REQ-021 SHALL drive rf_we = push, rf_wa = wr_ptr zero-extended to 5 bits, and rf_wd = in_data.
REQ-022 SHALL drive rf_ra = rd_ptr zero-extended to 5 bits and out_data = rf_rd, giving a show-ahead head with zero read latency.
REQ-023 SHALL advance wr_ptr by 1 on push and rd_ptr by 1 on pop, each modulo 2**DEPTH_LOG2, wrapping from 2**DEPTH_LOG2-1 to 0.
REQ-024 SHALL update count +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-025 SHALL ignore in_valid while full; no write and no pointer move.
REQ-026 SHALL ignore out_ready while empty.
REQ-027 SHALL, when a push occurs into an empty FIFO, assert out_valid in the cycle after the push edge and never in the same cycle.
REQ-028 SHALL, on flush=1, zero wr_ptr, rd_ptr and count at the edge, block any push that cycle (rf_we=0), and leave register-file contents unchanged.
REQ-029 SHALL treat entries after flush as stale and never present them.

Reset
REQ-030 SHALL, on rstn=0 at a clk edge, set wr_ptr=0, rd_ptr=0 and count=0, giving empty=1, full=0, in_ready=1, out_valid=0 and rf_we=0; rstn=0 overrides flush and any handshake.
REQ-031 SHALL abandon any transfer in flight during reset, with no write committed in a cycle where rstn=0.

Configuration
REQ-032 SHALL, with macro FIFO_CTRL_ALMOST_FLAGS_EN defined, add parameters AF_TH (default 2**DEPTH_LOG2-2) and AE_TH (default 2).
REQ-033 SHALL, with that macro defined, add registered outputs almost_full and almost_empty, asserted when count >= AF_TH and count <= AE_TH respectively, updated on the same edge as count and reset to 0 and 1.
REQ-034 SHALL, without FIFO_CTRL_ALMOST_FLAGS_EN, omit these parameters and ports entirely, with all other behaviour identical.

Structure
REQ-035 SHALL place the shared package constants RF_ADDR_W=5 and RF_DATA_W=32 in a package shared with the register file and neighbouring datapath blocks.
REQ-036 SHALL implement pointer increment and wrap in one sub-module fifo_ptr, instantiated twice (write and read).
REQ-037 SHALL NOT instantiate the register file; the enclosing level connects rf_* ports to it.

Verification
REQ-038 SHALL pass this scenario: after reset, push 0x11, 0x22, 0x33 on consecutive cycles -> count=3; out_data=0x11 one cycle after the first push; pops return 0x11, 0x22, 0x33 in order; then empty=1.
REQ-039 SHALL pass this scenario: DEPTH_LOG2=2, push 5 words with in_valid held -> full=1 after 4; 5th push stalls with in_ready=0; one pop frees a slot and the 5th is accepted; rf_wa wraps 3 -> 0.
REQ-040 SHALL pass this scenario: count=2, push and pop in the same cycle -> count stays 2, head advances, rf_we=1.
REQ-041 SHALL pass this scenario: 3 entries held, flush=1 with in_valid=1 -> next cycle count=0, empty=1, rf_we=0 during flush cycle.
REQ-042 SHALL pass this scenario: rstn=0 mid-stream at count=4 -> next cycle count=0, out_valid=0, in_ready=1, and later pushes start at rf_wa=0.
REQ-043 SHALL pass this scenario: with FIFO_CTRL_ALMOST_FLAGS_EN, DEPTH_LOG2=3 and defaults -> almost_full rises at count=6 and almost_empty falls at count=3.
